// File: rtl/bit_stuff.sv
// USB bit-stuffing stage ahead of the NRZI encoder: inserts a 0 after every
// run of STUFF_RUN ones, stalls the serializer for that cycle, counts stuffs per packet.
module bit_stuff #(
    parameter int STUFF_RUN = 6,
    parameter int CNT_W     = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             bstr_in,
    input  logic [1:0]       bstr_in_ready,
    output logic             bstr_in_stall,
    output logic             bstr_out,
    output logic [1:0]       bstr_out_ready,
    output logic [CNT_W-1:0] stuffed_out
);

    localparam int ONES_W = $clog2(STUFF_RUN + 1);
    localparam logic [ONES_W-1:0] RUN_LIM = ONES_W'(STUFF_RUN);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_STUFF} state_t;

    state_t            r_state, w_state_next;
    logic [ONES_W-1:0] r_ones, w_ones_next, w_ones_base, w_ones_inc;
    logic [1:0]        r_pkt_type, w_pkt_type_next;
    logic [CNT_W-1:0]  r_stuff_cnt, w_stuff_cnt_next;
    logic              r_out, w_out_next;
    logic [1:0]        r_out_type, w_out_type_next;
    logic              w_new_pkt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= S_IDLE;
            r_ones      <= '0;
            r_pkt_type  <= 2'b00;
            r_stuff_cnt <= '0;
            r_out       <= 1'b1;
            r_out_type  <= 2'b00;
        end else begin
            r_state     <= w_state_next;
            r_ones      <= w_ones_next;
            r_pkt_type  <= w_pkt_type_next;
            r_stuff_cnt <= w_stuff_cnt_next;
            r_out       <= w_out_next;
            r_out_type  <= w_out_type_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_ones_next      = r_ones;
        w_pkt_type_next  = r_pkt_type;
        w_stuff_cnt_next = r_stuff_cnt;
        w_out_next       = 1'b1;
        w_out_type_next  = 2'b00;
        // A type change without an idle gap also starts a fresh packet.
        w_new_pkt        = (r_state == S_IDLE) || (bstr_in_ready != r_pkt_type);
        w_ones_base      = w_new_pkt ? '0 : r_ones;
        w_ones_inc       = w_ones_base + ONES_W'(1);

        case (r_state)
            S_STUFF: begin
                w_out_next       = 1'b0;
                w_out_type_next  = r_pkt_type;
                w_ones_next      = '0;
                w_stuff_cnt_next = (&r_stuff_cnt) ? r_stuff_cnt : r_stuff_cnt + CNT_W'(1);
                w_state_next     = S_PASS;
            end
            default: begin
                if (bstr_in_ready == 2'b00) begin
                    w_ones_next  = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_out_next      = bstr_in;
                    w_out_type_next = bstr_in_ready;
                    w_pkt_type_next = bstr_in_ready;
                    w_state_next    = S_PASS;
                    if (w_new_pkt) begin
                        w_stuff_cnt_next = '0;
                    end
                    if (bstr_in) begin
                        w_ones_next = w_ones_inc;
                        if (w_ones_inc == RUN_LIM) begin
                            w_state_next = S_STUFF;
                        end
                    end else begin
                        w_ones_next = '0;
                    end
                end
            end
        endcase
    end

    assign bstr_in_stall  = (r_state == S_STUFF);
    assign bstr_out       = r_out;
    assign bstr_out_ready = r_out_type;
    assign stuffed_out    = r_stuff_cnt;

endmodule
